// File: rtl/sprite_palette_pkg.sv
// Shared types and helpers for the sprite palette lookup: 12-bit colour
// struct, per-channel inversion used by the flash effect, and the reset ramp.
package sprite_palette_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    function automatic rgb12_t inv_rgb(rgb12_t c);
        rgb12_t o;
        o.r = 4'hF - c.r;
        o.g = 4'hF - c.g;
        o.b = 4'hF - c.b;
        return o;
    endfunction

    // Only the low 4 index bits feed the ramp, so wide palettes repeat it.
    function automatic rgb12_t grey_ramp(int i);
        logic [3:0] n;
        n = 4'(i);
        return '{r: n, g: n, b: n};
    endfunction

endpackage

// File: rtl/sprite_palette_lut_flash_ctrl.sv
// Frame-counted flash phase: toggles every FLASH_FRAMES frame_start pulses
// while enabled, and is parked at phase 0 / count 0 while disabled.
module flash_ctrl #(
    parameter int FLASH_FRAMES = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_start_i,
    input  logic flash_en_i,
    output logic flash_phase_o
);

    localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    logic [CNT_W-1:0] frame_cnt_q;
    logic             phase_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (!flash_en_i) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (frame_start_i) begin
            // A pulse arriving with the enable edge already counts.
            if (frame_cnt_q == CNT_W'(FLASH_FRAMES - 1)) begin
                frame_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign flash_phase_o = phase_q;

endmodule

// File: rtl/sprite_palette_lut.sv
// Multi-bank runtime-loadable sprite palette with a 2-stage lookup pipeline,
// frame-synchronous bank switching, transparency flag and flash inversion.
module sprite_palette_lut
    import sprite_palette_pkg::*;
#(
    parameter int INDEX_W         = 4,
    parameter int NUM_BANKS       = 2,
    parameter int TRANSPARENT_IDX = 0,
    parameter int FLASH_FRAMES    = 4,
    localparam int BANK_W         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               in_valid,
    input  logic [INDEX_W-1:0] in_index,
    input  logic               wr_en,
    input  logic [BANK_W-1:0]  wr_bank,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [11:0]        wr_color,
    input  logic [BANK_W-1:0]  bank_sel,
    input  logic               frame_start,
    input  logic               flash_en,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               transparent,
    output logic               out_valid
);

    localparam int NUM_ENT = 2 ** INDEX_W;

    rgb12_t             pal_q [NUM_BANKS][NUM_ENT];
    logic [BANK_W-1:0]  pending_q, active_q;
    logic               s1_vld_q;
    logic [INDEX_W-1:0] s1_idx_q;
    logic [BANK_W-1:0]  s1_bank_q;
    rgb12_t             col_d, col_q;
    logic               trn_d, trn_q, vld_q;
    logic               flash_phase;

    flash_ctrl #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_start_i (frame_start),
        .flash_en_i    (flash_en),
        .flash_phase_o (flash_phase)
    );

    // Palette storage; reads elsewhere see the pre-edge contents, which gives
    // read-before-write when S2 and a write hit the same entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int i = 0; i < NUM_ENT; i++)
                    pal_q[b][i] <= grey_ramp(i);
        end else if (wr_en && (int'(wr_bank) < NUM_BANKS)) begin
            pal_q[wr_bank][wr_index] <= rgb12_t'(wr_color);
        end
    end

    // Out-of-range selections never reach active_q, so the array index is safe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pending_q <= '0;
            active_q  <= '0;
        end else begin
            pending_q <= bank_sel;
            if (frame_start && (int'(pending_q) < NUM_BANKS))
                active_q <= pending_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_vld_q  <= 1'b0;
            s1_idx_q  <= '0;
            s1_bank_q <= '0;
        end else begin
            s1_vld_q  <= in_valid;
            s1_idx_q  <= in_index;
            s1_bank_q <= active_q;
        end
    end

    // Flash uses the live enable so a disable lands on the very next pixel.
    always_comb begin
        col_d = pal_q[s1_bank_q][s1_idx_q];
        if (flash_en && flash_phase)
            col_d = inv_rgb(col_d);
        if (!s1_vld_q)
            col_d = '0;
        trn_d = s1_vld_q && (s1_idx_q == INDEX_W'(TRANSPARENT_IDX));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            col_q <= '0;
            trn_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            col_q <= col_d;
            trn_q <= trn_d;
            vld_q <= s1_vld_q;
        end
    end

    assign red         = col_q.r;
    assign green       = col_q.g;
    assign blue        = col_q.b;
    assign transparent = trn_q;
    assign out_valid   = vld_q;

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Directed bench for sprite_palette_lut: reset ramp, writes, bank switching,
// flash phases, streaming with gaps and asynchronous reset mid-stream.
module tb_sprite_palette_lut;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_index = '0;
    logic        wr_en = 1'b0;
    logic [0:0]  wr_bank = '0;
    logic [3:0]  wr_index = '0;
    logic [11:0] wr_color = '0;
    logic [0:0]  bank_sel = '0;
    logic        frame_start = 1'b0;
    logic        flash_en = 1'b0;
    logic [3:0]  red, green, blue;
    logic        transparent, out_valid;

    int checks = 0;
    int failures = 0;

    sprite_palette_lut dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .in_valid    (in_valid),
        .in_index    (in_index),
        .wr_en       (wr_en),
        .wr_bank     (wr_bank),
        .wr_index    (wr_index),
        .wr_color    (wr_color),
        .bank_sel    (bank_sel),
        .frame_start (frame_start),
        .flash_en    (flash_en),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .transparent (transparent),
        .out_valid   (out_valid)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Compares {out_valid, transparent, r, g, b} in one shot.
    task automatic check_out(input string tag, input logic [11:0] rgb,
                             input logic t, input logic v);
        logic [13:0] got, exp;
        got = {out_valid, transparent, red, green, blue};
        exp = {v, t, rgb};
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic lookup(input logic [3:0] idx);
        in_valid = 1'b1;
        in_index = idx;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic write(input logic b, input logic [3:0] idx, input logic [11:0] c);
        wr_en = 1'b1; wr_bank = b; wr_index = idx; wr_color = c;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    initial begin
        logic [11:0] exp_c;
        logic [11:0] g;

        #2;
        check_out("reset_outputs", 12'h000, 1'b0, 1'b0);
        step();
        Reset = 1'b0;
        step();
        check_out("idle_after_reset", 12'h000, 1'b0, 1'b0);

        lookup(4'd5);
        check_out("grey_idx5", 12'h555, 1'b0, 1'b1);
        lookup(4'd0);
        check_out("grey_idx0_transp", 12'h000, 1'b1, 1'b1);

        // Mid-frame bank select must not switch until frame_start.
        write(1'b1, 4'd3, 12'hFA0);
        bank_sel = 1'b1;
        step();
        lookup(4'd3);
        check_out("midframe_still_bank0", 12'h333, 1'b0, 1'b1);
        pulse_frame();
        lookup(4'd3);
        check_out("bank1_written", 12'hFA0, 1'b0, 1'b1);

        // Write landing while S1 holds the same entry: old then new.
        in_valid = 1'b1; in_index = 4'd7;
        step();
        wr_en = 1'b1; wr_bank = 1'b1; wr_index = 4'd7; wr_color = 12'h5C9;
        step();
        wr_en = 1'b0; in_valid = 1'b0;
        check_out("rbw_old", 12'h777, 1'b0, 1'b1);
        step();
        check_out("rbw_new", 12'h5C9, 1'b0, 1'b1);

        // Flash: enabled without a pulse, so frame 0 lasts until the first pulse.
        write(1'b1, 4'd2, 12'h123);
        flash_en = 1'b1;
        step();
        for (int f = 0; f < 12; f++) begin
            exp_c = (((f / 4) % 2) == 1) ? 12'hEDC : 12'h123;
            lookup(4'd2);
            check_out($sformatf("flash_frame%0d", f), exp_c, 1'b0, 1'b1);
            if (f == 0 || f == 4) begin
                lookup(4'd0);
                check_out($sformatf("flash_transp_frame%0d", f),
                          (f == 4) ? 12'hFFF : 12'h000, 1'b1, 1'b1);
            end
            pulse_frame();
        end
        // 12 pulses leave the phase inverted; disable must act on the next pixel.
        flash_en = 1'b0;
        lookup(4'd2);
        check_out("flash_disable", 12'h123, 1'b0, 1'b1);

        // Pulse coinciding with enable counts as the first of four.
        flash_en = 1'b1;
        pulse_frame();
        pulse_frame();
        pulse_frame();
        lookup(4'd2);
        check_out("flash_rise_3pulses", 12'h123, 1'b0, 1'b1);
        pulse_frame();
        lookup(4'd2);
        check_out("flash_rise_4pulses", 12'hEDC, 1'b0, 1'b1);
        flash_en = 1'b0;
        step();

        // Stream 16 indices on bank 0; output lags the request by one check.
        bank_sel = 1'b0;
        step();
        pulse_frame();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_index = 4'(i);
            step();
            if (i == 0) begin
                check_out("stream_first_invalid", 12'h000, 1'b0, 1'b0);
            end else begin
                g = {3{4'(i - 1)}};
                check_out($sformatf("stream_%0d", i - 1), g, (i == 1), 1'b1);
            end
        end
        in_valid = 1'b0;
        step();
        check_out("stream_15", 12'hFFF, 1'b0, 1'b1);
        step();
        check_out("stream_end_gap", 12'h000, 1'b0, 1'b0);

        // Single-cycle gap inside a stream.
        in_valid = 1'b1; in_index = 4'd9;
        step();
        in_valid = 1'b0;
        step();
        check_out("gap_before", 12'h999, 1'b0, 1'b1);
        in_valid = 1'b1; in_index = 4'd10;
        step();
        in_valid = 1'b0;
        check_out("gap_zeroed", 12'h000, 1'b0, 1'b0);
        step();
        check_out("gap_after", 12'hAAA, 1'b0, 1'b1);

        // Async reset between edges while streaming.
        write(1'b0, 4'd4, 12'hABC);
        in_valid = 1'b1; in_index = 4'd4;
        step();
        step();
        check_out("pre_reset_written", 12'hABC, 1'b0, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check_out("async_reset_immediate", 12'h000, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        Reset = 1'b0;
        step();
        check_out("post_reset_idle", 12'h000, 1'b0, 1'b0);
        lookup(4'd4);
        check_out("post_reset_grey", 12'h444, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
